// File: rtl/mult_sched_pkg.sv
// Shared constants and state encoding for the round-robin multiplier scheduler.
package mult_sched_pkg;
  localparam int OP_W        = 4;
  localparam int PROD_W      = 8;
  localparam int DEF_N_REQ   = 4;
  localparam int DEF_TIMEOUT = 32;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_e;
endpackage

// File: rtl/mult_scheduler_if.sv
// Requester-side and multiplier-side buses of the scheduler.
interface mult_req_if #(parameter int N_REQ = mult_sched_pkg::DEF_N_REQ);
  import mult_sched_pkg::*;
  logic [N_REQ-1:0]           Req;
  logic [N_REQ-1:0][OP_W-1:0] OpA;
  logic [N_REQ-1:0][OP_W-1:0] OpB;
  logic [N_REQ-1:0]           Ack;
  logic [PROD_W-1:0]          Result;
  logic                       Err;

  modport master (output Req, OpA, OpB, input  Ack, Result, Err);
  modport slave  (input  Req, OpA, OpB, output Ack, Result, Err);
endinterface

interface mult_mul_if;
  import mult_sched_pkg::*;
  logic              M_St;
  logic [OP_W-1:0]   M_Multiplicando;
  logic [OP_W-1:0]   M_Multiplicador;
  logic              M_Idle;
  logic              M_Done;
  logic [PROD_W-1:0] M_Produto;

  modport master (output M_St, M_Multiplicando, M_Multiplicador, input  M_Idle, M_Done, M_Produto);
  modport slave  (input  M_St, M_Multiplicando, M_Multiplicador, output M_Idle, M_Done, M_Produto);
endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request at or after i_ptr, wrapping.
module rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int IW    = 2
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [IW-1:0]    i_ptr,
  output logic [IW-1:0]    o_idx,
  output logic             o_vld
);
  logic [IW-1:0] w_cand;

  always_comb begin
    o_idx  = '0;
    o_vld  = 1'b0;
    w_cand = '0;
    for (int k = 0; k < N_REQ; k++) begin
      w_cand = IW'((int'(i_ptr) + k) % N_REQ);
      if (!o_vld && i_req[w_cand]) begin
        o_vld = 1'b1;
        o_idx = w_cand;
      end
    end
  end
endmodule

// File: rtl/mult_scheduler.sv
// Shares one shift-add multiplier among N_REQ requesters: round-robin grant,
// one St pulse per job, watchdog abort, one-cycle Ack with the 8-bit product.
module mult_scheduler
  import mult_sched_pkg::*;
#(
  parameter int N_REQ   = DEF_N_REQ,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic       Clk,
  input  logic       reset,
  mult_req_if.slave  req,
  mult_mul_if.master mul
);
  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CW = $clog2(TIMEOUT);

  state_e            r_state;
  logic [IW-1:0]     r_ptr;
  logic [IW-1:0]     r_gnt;
  logic [OP_W-1:0]   r_opa;
  logic [OP_W-1:0]   r_opb;
  logic              r_st;
  logic [CW-1:0]     r_cnt;
  logic [PROD_W-1:0] r_res;
  logic              r_err;

  logic [IW-1:0]     w_idx;
  logic              w_vld;
  logic [IW-1:0]     w_ptr_nxt;
  logic [N_REQ-1:0]  w_ack;

  rr_arbiter #(.N_REQ(N_REQ), .IW(IW)) u_arb (
    .i_req (req.Req),
    .i_ptr (r_ptr),
    .o_idx (w_idx),
    .o_vld (w_vld)
  );

  assign w_ptr_nxt = (r_gnt == IW'(N_REQ - 1)) ? '0 : r_gnt + IW'(1);

  always_ff @(posedge Clk) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_ptr   <= '0;
      r_gnt   <= '0;
      r_opa   <= '0;
      r_opb   <= '0;
      r_st    <= 1'b0;
      r_cnt   <= '0;
      r_res   <= '0;
      r_err   <= 1'b0;
    end else begin
      r_st <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (mul.M_Idle && w_vld) begin
            r_gnt   <= w_idx;
            r_opa   <= req.OpA[w_idx];
            r_opb   <= req.OpB[w_idx];
            r_st    <= 1'b1;
            r_state <= S_START;
          end
        end
        S_START: begin
          r_cnt   <= '0;
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          r_cnt <= r_cnt + CW'(1);
          // Done wins over the watchdog if both land in the same cycle.
          if (mul.M_Done) begin
            r_res   <= mul.M_Produto;
            r_err   <= 1'b0;
            r_state <= S_RESP;
          end else if (r_cnt == CW'(TIMEOUT - 1)) begin
            r_res   <= '0;
            r_err   <= 1'b1;
            r_state <= S_RESP;
          end
        end
        S_RESP: begin
          r_ptr   <= w_ptr_nxt;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    w_ack = '0;
    if (r_state == S_RESP) w_ack[r_gnt] = 1'b1;
  end

  assign req.Ack             = w_ack;
  assign req.Result          = (r_state == S_RESP) ? r_res : '0;
  assign req.Err             = (r_state == S_RESP) && r_err;
  assign mul.M_St            = r_st;
  assign mul.M_Multiplicando = r_opa;
  assign mul.M_Multiplicador = r_opb;
endmodule

// File: tb/tb_mult_scheduler.sv
// Randomized self-checking bench: behavioural multiplier model plus a
// round-robin service-order scoreboard.
module tb_mult_scheduler;
  import mult_sched_pkg::*;
  localparam int N  = 4;
  localparam int TO = 32;

  logic Clk = 1'b0;
  logic reset = 1'b0;
  always #5 Clk = ~Clk;

  mult_req_if #(.N_REQ(N)) rq();
  mult_mul_if mm();

  mult_scheduler #(.N_REQ(N), .TIMEOUT(TO)) dut (
    .Clk   (Clk),
    .reset (reset),
    .req   (rq),
    .mul   (mm)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Multiplier model: Done LAT cycles after St, product from the operands it sees.
  int m_lat = 5;
  bit m_hang = 0;
  bit m_busy_force = 0;
  bit m_inj = 0;
  bit m_busy = 0;
  int m_cnt = 0;
  int st_seen = 0;

  always @(negedge Clk) begin
    mm.M_Done    = 1'b0;
    mm.M_Produto = '0;
    if (!reset) begin
      m_busy = 0;
      m_cnt  = 0;
    end else begin
      if (mm.M_St) begin
        st_seen++;
        if (!m_hang) begin
          m_busy = 1;
          m_cnt  = m_lat;
        end
      end else if (m_busy) begin
        if (m_cnt > 1) m_cnt--;
        else begin
          mm.M_Done    = 1'b1;
          mm.M_Produto = 8'(mm.M_Multiplicando) * 8'(mm.M_Multiplicador);
          m_busy       = 0;
        end
      end
      if (m_inj) begin
        mm.M_Done    = 1'b1;
        mm.M_Produto = 8'hAA;
        m_inj        = 0;
      end
    end
    mm.M_Idle = !m_busy && !m_busy_force;
  end

  // Requester state and scoreboard
  logic [N-1:0] req_v;
  logic [3:0]   opa [N];
  logic [3:0]   opb [N];
  int           m_ptr = 0;

  task automatic tick();
    @(negedge Clk);
    #1;
  endtask

  task automatic drive();
    rq.Req = req_v;
    for (int i = 0; i < N; i++) begin
      rq.OpA[i] = opa[i];
      rq.OpB[i] = opb[i];
    end
  endtask

  function automatic int rr_pick(input logic [N-1:0] v, input int p);
    for (int k = 0; k < N; k++)
      if (v[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  // Serve n transactions in predicted order. keep: winner re-requests after Ack.
  // scram: once St is seen, scramble the winner's operands (and drop Req if !keep).
  task automatic serve(input int n, input bit keep, input bit scram, input int lat0, input int latn);
    for (int s = 0; s < n; s++) begin
      int exp_g, cyc, st0;
      logic [7:0] exp_p;
      bit got, scr_done;
      exp_g = rr_pick(req_v, m_ptr);
      if (exp_g < 0) return;
      exp_p = m_hang ? 8'h00 : 8'(opa[exp_g]) * 8'(opb[exp_g]);
      st0 = st_seen; cyc = 0; got = 0; scr_done = 0;
      while (!got && cyc < 100) begin
        tick();
        cyc++;
        if (rq.Ack != '0) got = 1;
        else begin
          chk("quiet_out", {23'd0, rq.Result, rq.Err}, 32'd0);
          if (scram && !scr_done && st_seen != st0) begin
            opa[exp_g] = 4'($urandom);
            opb[exp_g] = 4'($urandom);
            if (!keep) req_v[exp_g] = 1'b0;
            drive();
            scr_done = 1;
          end
        end
      end
      if (!got) begin
        chk("ack_timeout", 32'd0, 32'd1);
        return;
      end
      chk("ack_vec", rq.Ack, 32'd1 << exp_g);
      chk("result", rq.Result, exp_p);
      chk("err", rq.Err, m_hang);
      chk("latency", cyc, (s == 0) ? lat0 : latn);
      chk("st_pulses", st_seen - st0, 1);
      m_ptr = (exp_g + 1) % N;
      if (!keep) req_v[exp_g] = 1'b0;
      if (s == n - 1) req_v = '0;
      drive();
    end
    tick();
    chk("ack_one_cycle", rq.Ack, 32'd0);
  endtask

  task automatic set_one(input int i, input int a, input int b);
    opa[i] = 4'(a);
    opb[i] = 4'(b);
    req_v = '0;
    req_v[i] = 1'b1;
    drive();
  endtask

  initial begin
    req_v = '0;
    for (int i = 0; i < N; i++) begin opa[i] = '0; opb[i] = '0; end
    drive();

    // Reset state
    reset = 1'b0;
    repeat (3) tick();
    chk("rst_ack", rq.Ack, 0);
    chk("rst_result", rq.Result, 0);
    chk("rst_err", rq.Err, 0);
    chk("rst_st", mm.M_St, 0);
    chk("rst_opa", mm.M_Multiplicando, 0);
    chk("rst_opb", mm.M_Multiplicador, 0);
    reset = 1'b1;
    m_ptr = 0;
    tick();

    // Contention: all four held, operands (i+1)x(i+2), order 0,1,2,3,0
    for (int i = 0; i < N; i++) begin opa[i] = 4'(i + 1); opb[i] = 4'(i + 2); end
    req_v = '1;
    drive();
    serve(5, 1'b1, 1'b0, m_lat + 2, m_lat + 3);

    // Single request 13 x 11 = 143
    set_one(0, 13, 11);
    serve(1, 1'b0, 1'b0, m_lat + 2, m_lat + 3);

    // Corner products
    set_one(1, 15, 15); serve(1, 1'b0, 1'b0, m_lat + 2, m_lat + 3);
    set_one(2, 0, 9);   serve(1, 1'b0, 1'b0, m_lat + 2, m_lat + 3);
    set_one(3, 1, 15);  serve(1, 1'b0, 1'b0, m_lat + 2, m_lat + 3);

    // Stray Done while idle must not produce an Ack
    m_inj = 1;
    repeat (4) begin
      tick();
      chk("stray_done_ack", rq.Ack, 0);
    end
    set_one(0, 9, 7);
    serve(1, 1'b0, 1'b0, m_lat + 2, m_lat + 3);

    // Watchdog then normal service
    m_hang = 1;
    set_one(2, 7, 7);
    serve(1, 1'b0, 1'b0, TO + 2, TO + 3);
    m_hang = 0;
    set_one(2, 6, 9);
    serve(1, 1'b0, 1'b0, m_lat + 2, m_lat + 3);

    // Busy multiplier holds off the grant
    m_busy_force = 1;
    tick();
    set_one(1, 5, 12);
    begin
      int st0;
      st0 = st_seen;
      repeat (10) begin
        tick();
        chk("busy_no_ack", rq.Ack, 0);
      end
      chk("busy_no_st", st_seen - st0, 0);
    end
    m_busy_force = 0;
    serve(1, 1'b0, 1'b0, m_lat + 3, m_lat + 3);

    // Reset mid-WAIT: ptr is 2 here, so 3 would win; after reset 1 must win
    opa[1] = 4'd3; opb[1] = 4'd4; opa[3] = 4'd11; opb[3] = 4'd2;
    req_v = 4'b1010;
    drive();
    repeat (4) tick();
    reset = 1'b0;
    tick();
    chk("rstw_ack", rq.Ack, 0);
    chk("rstw_result", rq.Result, 0);
    chk("rstw_err", rq.Err, 0);
    chk("rstw_st", mm.M_St, 0);
    chk("rstw_opa", mm.M_Multiplicando, 0);
    chk("rstw_opb", mm.M_Multiplicador, 0);
    reset = 1'b1;
    m_ptr = 0;
    serve(2, 1'b0, 1'b0, m_lat + 2, m_lat + 3);

    // Randomized rounds
    for (int r = 0; r < 25; r++) begin
      bit keep, scram;
      int n;
      m_lat = $urandom_range(1, 9);
      req_v = N'($urandom_range(1, (1 << N) - 1));
      for (int i = 0; i < N; i++) begin opa[i] = 4'($urandom); opb[i] = 4'($urandom); end
      keep  = ($urandom_range(0, 3) == 0);
      scram = $urandom_range(0, 1) == 1;
      n = keep ? $urandom_range(1, 6) : $countones(req_v);
      drive();
      serve(n, keep, scram, m_lat + 2, m_lat + 3);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/mult_scheduler.md
# mult_scheduler

Round-robin scheduler that shares one 4×4 shift-add multiplier (`Multiplicador` datapath: ACC/Adder/CONTROL/Counter) among `N_REQ` requesters. It sits between requester ports and the multiplier's `St`/`Done`/`Idle` handshake. It latches the winning requester's operands, sequences one multiplication, and returns the 8-bit product with a one-cycle acknowledge. A watchdog aborts a transaction if the multiplier never reports `Done`.

## Interface
- `N_REQ`, default 4: number of requesters, 2..8.
- `TIMEOUT`, default 32: maximum cycles in WAIT before abort, ≥ 12.
- `Clk`  in  1  system clock; all logic on the rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `Req`  in  N_REQ  request per requester; held high with operands stable until its `Ack`.
- `OpA`  in  4*N_REQ  multiplicand; requester i uses bits [4i+3:4i].
- `OpB`  in  4*N_REQ  multiplier operand; same packing as `OpA`.
- `Ack`  out  N_REQ  one-hot, one-cycle completion strobe.
- `Result`  out  8  product; valid only while any `Ack` bit is high, otherwise 0.
- `Err`  out  1  high together with `Ack` when the transaction timed out.
- `M_St`  out  1  start pulse to multiplier.
- `M_Multiplicando`, `M_Multiplicador`  out  4 each  registered operands to multiplier.
- `M_Idle`  in  1  multiplier ready for `St`.
- `M_Done`  in  1  multiplier finished; `M_Produto` valid in the same cycle.
- `M_Produto`  in  8  multiplier product.

## Operation
- FSM states: IDLE, START, WAIT, RESP.
- IDLE: when `M_Idle`=1 and `Req`≠0, pick the winner g by round-robin from pointer `ptr`, searching `ptr`, `ptr`+1, … mod N_REQ. Latch g, OpA[g] and OpB[g] into the operand registers, then go to START. With no request, or `M_Idle`=0, stay in IDLE.
- START: `M_St`=1 for exactly this cycle. Clear the watchdog counter. Go to WAIT.
- WAIT: `M_St`=0 and the counter increments each cycle.
  - `M_Done`=1: capture `M_Produto` into the result register and go to RESP. Err flag = 0.
  - Counter reaches `TIMEOUT`-1 without `M_Done`: result register = 0, Err flag = 1, go to RESP.
- RESP: `Ack[g]`=1, `Result` = result register, `Err` = Err flag. Set `ptr` = (g+1) mod N_REQ. Go to IDLE.
- Requester rules:
  - `Req[g]` still high in the cycle after its `Ack` is a new request.
  - A requester dropping `Req` before its `Ack` does not cancel the transaction. The `Ack` is still issued.
- Operand registers hold their value from latch until the next grant. Changes on `OpA`/`OpB` after the grant are ignored.
- Widths: `Result` is the full 8-bit product, with no truncation. 15×15 = 225 = 8'hE1.
- `M_Done` seen in any state other than WAIT is ignored.

## Timing
- Reset (`reset`=0 at an edge): state IDLE, `ptr`=0, and `Ack`, `Result`, `Err`, `M_St`, operand registers and counter all 0. Applies from any state, including mid-WAIT. Reset mid-transaction produces no `Ack` for the aborted transaction.
- Minimum latency from `Req` seen in IDLE to `Ack`:
  - edge 0 grant, edge 1 START, edge 2 WAIT entry;
  - `Ack` occurs one cycle after the `M_Done` cycle.
  - Total = 3 + (cycles in WAIT).
- With the standard multiplier (4 bit iterations plus done), `Ack` follows grant by ≤ 14 cycles.
- Back-to-back: after RESP, the next grant is possible on the very next IDLE cycle, provided `M_Idle`=1.
- Outputs are registered, except `Ack`/`Result`/`Err`, which decode the RESP state plus registers. No combinational path from `M_*` inputs to outputs.

## Structure
- Shared package `mult_sched_pkg`:
  - state encoding constants S_IDLE=2'd0, S_START=2'd1, S_WAIT=2'd2, S_RESP=2'd3;
  - default `N_REQ`/`TIMEOUT`;
  - operand width 4 and product width 8.
- One sub-module, `rr_arbiter`: combinational round-robin pick of the index and a valid flag from `Req` and `ptr`. The `ptr` register stays in `mult_scheduler`.

## Test plan
- Single request: Req=4'b0001, OpA[0]=4'd13, OpB[0]=4'd11 → one `M_St` pulse; `Ack`=4'b0001 once with `Result`=8'd143, `Err`=0.
- Contention: Req=4'b1111 held, operands i+1 × i+2 → `Ack` order 0,1,2,3,0. Results 2, 6, 12, 20. `ptr` wraps from 3 to 0.
- Corner products: 15×15 → 8'hE1; 0×9 → 8'h00; 1×15 → 8'h0F.
- Watchdog: model holds `M_Done`=0 → after `TIMEOUT` WAIT cycles, `Ack[g]`=1, `Err`=1, `Result`=0; the next request is served normally.
- Reset in WAIT: assert `reset`=0 for one cycle mid-transaction → all outputs 0 and `ptr`=0 next cycle. No stray `Ack`. The pending `Req` is re-granted from requester 0's priority.
- Busy multiplier: `M_Idle`=0 with Req=4'b0010 → no grant and no `M_St` until `M_Idle`=1. Then the grant follows on the first such cycle.
